// File: rtl/two_ch_acq_ctrl.sv
// Two-channel acquisition frame sequencer: clears and arms both samplers, waits for
// their buffers to fill, then streams tagged samples (A then B per index) over valid/ready.
module two_ch_acq_ctrl #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 14,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned TO_W    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] cfg_target_A,
    input  logic [AW-1:0] cfg_target_B,
    output logic          smp_clear,
    output logic [AW-1:0] sample_target_A,
    output logic [AW-1:0] sample_target_B,
    input  logic          done_A,
    input  logic          done_B,
    output logic [AW-1:0] read_index,
    input  logic [DW-1:0] data_out_A,
    input  logic [DW-1:0] data_out_B,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          frame_done,
    output logic          timeout_err
);
    localparam int unsigned SW = 14;
    localparam int unsigned CW = (TO_W > 8) ? TO_W : 8;
    localparam logic [CW-1:0] TO_LAST  = CW'((64'd1 << TO_W) - 64'd2);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_DONE, S_RD_ADDR, S_RD_WAIT, S_SEND_A, S_SEND_B
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] n_idx;
    logic [SW-1:0] hold_b;
    logic          start_ok;
    logic          abort_hit;
    logic          in_a;
    logic          in_b;
    logic          more;
    logic          both_done;
    logic          captured;

    logic          smp_clear_d;
    logic          busy_d;
    logic          out_valid_d;
    logic [15:0]   out_data_d;
    logic          out_last_d;
    logic          frame_done_d;
    logic          timeout_err_d;

    assign start_ok  = start & ~abort;
    assign abort_hit = abort & (state != S_IDLE);
    assign n_idx     = (sample_target_A > sample_target_B) ? sample_target_A : sample_target_B;
    assign idx_inc   = idx + AW'(1);
    assign in_a      = idx < sample_target_A;
    assign in_b      = idx < sample_target_B;
    assign more      = idx_inc < n_idx;
    // A zero-target channel has nothing to collect, so its done flag is irrelevant
    assign both_done = (done_A | (sample_target_A == '0)) & (done_B | (sample_target_B == '0));
    assign captured  = ((state == S_RD_ADDR) || (state == S_RD_WAIT)) && (cnt == RD_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; empty SEND slots are bypassed so they cost no cycles
    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:      if (start_ok) state_nxt = S_CLEAR;
                S_CLEAR:     if (cnt == CLR_LAST) state_nxt = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (both_done)           state_nxt = (n_idx == '0) ? S_IDLE : S_RD_ADDR;
                    else if (cnt == TO_LAST) state_nxt = S_IDLE;
                end
                S_RD_ADDR, S_RD_WAIT: begin
                    if (captured) state_nxt = in_a ? S_SEND_A : S_SEND_B;
                    else          state_nxt = S_RD_WAIT;
                end
                S_SEND_A: if (out_ready) state_nxt = in_b ? S_SEND_B : (more ? S_RD_ADDR : S_IDLE);
                S_SEND_B: if (out_ready) state_nxt = more ? S_RD_ADDR : S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        smp_clear_d   = (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
        busy_d        = (state_nxt != S_IDLE);
        out_valid_d   = (state_nxt == S_SEND_A) || (state_nxt == S_SEND_B);
        out_data_d    = out_data;
        out_last_d    = out_last;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err;
        if ((state == S_IDLE) && start_ok) timeout_err_d = 1'b0;
        if (!abort_hit) begin
            unique case (state)
                S_WAIT_DONE: begin
                    if (both_done)           frame_done_d  = (n_idx == '0);
                    else if (cnt == TO_LAST) timeout_err_d = 1'b1;
                end
                S_RD_ADDR, S_RD_WAIT: begin
                    if (captured) begin
                        if (in_a) begin
                            out_data_d = {2'b00, SW'(data_out_A)};
                            out_last_d = ~more & ~in_b;
                        end else begin
                            out_data_d = {2'b10, SW'(data_out_B)};
                            out_last_d = ~more;
                        end
                    end
                end
                S_SEND_A: begin
                    if (out_ready) begin
                        if (in_b) begin
                            out_data_d = {2'b10, hold_b};
                            out_last_d = ~more;
                        end else begin
                            frame_done_d = ~more;
                        end
                    end
                end
                S_SEND_B: if (out_ready) frame_done_d = ~more;
                default: ;
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp_clear   <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            smp_clear   <= smp_clear_d;
            busy        <= busy_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            out_last    <= out_last_d;
            frame_done  <= frame_done_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Datapath: shared phase counter, index, targets and B holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt             <= '0;
            idx             <= '0;
            hold_b          <= '0;
            read_index      <= '0;
            sample_target_A <= '0;
            sample_target_B <= '0;
        end else begin
            if ((state_nxt != state) && !((state == S_RD_ADDR) && (state_nxt == S_RD_WAIT)))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if ((state == S_IDLE) && start_ok) begin
                sample_target_A <= cfg_target_A;
                sample_target_B <= cfg_target_B;
            end
            if (captured) hold_b <= SW'(data_out_B);
            if (state_nxt == S_IDLE) begin
                idx        <= '0;
                read_index <= '0;
            end else if ((state_nxt == S_RD_ADDR) && ((state == S_SEND_A) || (state == S_SEND_B))) begin
                idx        <= idx_inc;
                read_index <= idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_two_ch_acq_ctrl.sv
// Bench for two_ch_acq_ctrl: sampler model with read latency, word scoreboard,
// table of frame vectors plus abort and mid-frame reset sequences.
module tb_two_ch_acq_ctrl;
    localparam int unsigned AW      = 10;
    localparam int unsigned DW      = 14;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned CLR_CYC = 2;
    localparam int unsigned TO_W    = 6;
    localparam int          BUDGET  = 3000;
    localparam int          NV      = 7;

    typedef struct {
        int ta;
        int tb;
        int dly_a;
        int dly_b;
        int mode;
        bit exp_to;
        bit restart;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_target_A;
    logic [AW-1:0] cfg_target_B;
    logic          smp_clear;
    logic [AW-1:0] sample_target_A;
    logic [AW-1:0] sample_target_B;
    logic          done_A;
    logic          done_B;
    logic [AW-1:0] read_index;
    logic [DW-1:0] data_out_A;
    logic [DW-1:0] data_out_B;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    word_t         exp_q[$];
    int            n_checks = 0;
    int            n_err    = 0;
    int            words, fd_cnt, clr_cyc, wait_cyc, vld_cyc, ri_steps, ri_bad;
    logic [AW-1:0] ri_prev;
    bit            stall_prev;
    logic [15:0]   stall_data;
    logic          stall_last;
    bit            tb_abort;
    logic [13:0]   seed;
    logic [AW-1:0] pipe [RD_LAT];
    vec_t          vecs [NV];

    always #5 clk = ~clk;

    two_ch_acq_ctrl #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CLR_CYC(CLR_CYC), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_target_A(cfg_target_A), .cfg_target_B(cfg_target_B),
        .smp_clear(smp_clear), .sample_target_A(sample_target_A), .sample_target_B(sample_target_B),
        .done_A(done_A), .done_B(done_B), .read_index(read_index),
        .data_out_A(data_out_A), .data_out_B(data_out_B),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    function automatic logic [13:0] fa(input logic [AW-1:0] i, input logic [13:0] s);
        return {4'h1, i} ^ s;
    endfunction

    function automatic logic [13:0] fb(input logic [AW-1:0] i, input logic [13:0] s);
        return {4'h2, i} + s;
    endfunction

    // Sampler buffer read with RD_LAT register stages
    always @(posedge clk) begin
        pipe[0] <= read_index;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign data_out_A = fa(pipe[RD_LAT-1], seed);
    assign data_out_B = fb(pipe[RD_LAT-1], seed);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, per-frame statistics
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (busy && smp_clear) clr_cyc++;
            if (busy && !smp_clear && !out_valid) wait_cyc++;
            if (out_valid) vld_cyc++;
            if (frame_done) fd_cnt++;
            if (busy && (read_index != ri_prev)) begin
                if (read_index == ri_prev + AW'(1)) ri_steps++;
                else ri_bad++;
                ri_prev = read_index;
            end
            if (stall_prev && !tb_abort) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(stall_data));
                check("stall_last", 32'(out_last), 32'(stall_last));
            end
            if (out_valid && out_ready) begin
                words++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", 32'(out_data), 32'(w.data));
                    check("word_last", 32'(out_last), 32'(w.last));
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end
    end

    task automatic build_expected(input int ta, input int tb);
        word_t w;
        int    n;
        int    k;
        int    total;
        exp_q.delete();
        n     = (ta > tb) ? ta : tb;
        total = ta + tb;
        k     = 0;
        for (int i = 0; i < n; i++) begin
            if (i < ta) begin
                w.data = {2'b00, fa(AW'(i), seed)};
                w.last = (k == total - 1);
                exp_q.push_back(w);
                k++;
            end
            if (i < tb) begin
                w.data = {2'b10, fb(AW'(i), seed)};
                w.last = (k == total - 1);
                exp_q.push_back(w);
                k++;
            end
        end
    endtask

    task automatic clear_stats();
        words = 0; fd_cnt = 0; clr_cyc = 0; wait_cyc = 0; vld_cyc = 0;
        ri_steps = 0; ri_bad = 0; ri_prev = '0; tb_abort = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int cyc;
        int armed;
        int n;
        bit ended;
        cfg_target_A = AW'(v.ta);
        cfg_target_B = AW'(v.tb);
        seed         = 14'($urandom);
        n            = (v.ta > v.tb) ? v.ta : v.tb;
        if (!v.exp_to) build_expected(v.ta, v.tb);
        else exp_q.delete();
        clear_stats();
        done_A = 1'b0; done_B = 1'b0; out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_clears_timeout", 32'(timeout_err), 32'd0);
        cyc = 0; armed = 0; ended = 1'b0;
        while (!ended && cyc < BUDGET) begin
            out_ready = (v.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (!smp_clear) armed++;
            done_A = (v.dly_a >= 0) && (armed > v.dly_a);
            done_B = (v.dly_b >= 0) && (armed > v.dly_b);
            if (v.restart && cyc == 5) begin
                cfg_target_A = AW'(77);
                cfg_target_B = AW'(66);
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (!busy) ended = 1'b1;
        end
        start = 1'b0; done_A = 1'b0; done_B = 1'b0; out_ready = 1'b1;
        if (!ended) begin
            n_checks++;
            n_err++;
            $display("FAIL frame_end: busy still 1 after %0d cycles, expected 0", BUDGET);
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_words", 32'(words), v.exp_to ? 32'd0 : 32'(v.ta + v.tb));
        check("frame_done_cnt", 32'(fd_cnt), v.exp_to ? 32'd0 : 32'd1);
        check("clear_cycles", 32'(clr_cyc), 32'(CLR_CYC));
        check("timeout_err", 32'(timeout_err), 32'(v.exp_to));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (v.exp_to) check("timeout_wait_cycles", 32'(wait_cyc), 32'd63);
        if (!v.exp_to && n > 0) begin
            check("read_index_steps", 32'(ri_steps), 32'(n - 1));
            check("read_index_jumps", 32'(ri_bad), 32'd0);
        end
        if (!v.exp_to && v.mode == 0) check("valid_cycles", 32'(vld_cyc), 32'(words));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_smp_clear", 32'(smp_clear), 32'd1);
        check("idle_read_index", 32'(read_index), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("latched_target_A", 32'(sample_target_A), 32'(v.ta));
        check("latched_target_B", 32'(sample_target_B), 32'(v.tb));
        exp_q.delete();
    endtask

    // Abort while word B2 is stalled in SEND_B
    task automatic abort_test();
        int cyc;
        cfg_target_A = AW'(4);
        cfg_target_B = AW'(4);
        seed         = 14'($urandom);
        build_expected(4, 4);
        clear_stats();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (words < 5 && cyc < BUDGET) begin
            done_A = !smp_clear;
            done_B = !smp_clear;
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach_b2", 32'(words), 32'd5);
        out_ready = 1'b0;
        check("abort_pre_valid", 32'(out_valid), 32'd1);
        check("abort_pre_data", 32'(out_data), 32'({2'b10, fb(AW'(2), seed)}));
        abort    = 1'b1;
        tb_abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_smp_clear", 32'(smp_clear), 32'd1);
        check("abort_read_index", 32'(read_index), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_frame_done", 32'(fd_cnt), 32'd0);
        check("abort_words", 32'(words), 32'd5);
        check("abort_words_left", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        done_A = 1'b0; done_B = 1'b0; out_ready = 1'b1; tb_abort = 1'b0;
    endtask

    // Asynchronous reset in the middle of streaming
    task automatic reset_test();
        int cyc;
        cfg_target_A = AW'(3);
        cfg_target_B = AW'(3);
        seed         = 14'($urandom);
        build_expected(3, 3);
        clear_stats();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (words < 2 && cyc < BUDGET) begin
            done_A = !smp_clear;
            done_B = !smp_clear;
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_reach_words", 32'(words), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_smp_clear", 32'(smp_clear), 32'd1);
        check("rst_read_index", 32'(read_index), 32'd0);
        check("rst_target_A", 32'(sample_target_A), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        done_A = 1'b0; done_B = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cfg_target_A = '0; cfg_target_B = '0; done_A = 1'b0; done_B = 1'b0;
        seed = '0; tb_abort = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("reset_smp_clear", 32'(smp_clear), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_timeout_err", 32'(timeout_err), 32'd0);
        check("reset_read_index", 32'(read_index), 32'd0);
        check("reset_target_A", 32'(sample_target_A), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        //          ta  tb  dly_a dly_b mode to restart
        vecs[0] = '{4,  4,  50,   50,   0,   0, 1};
        vecs[1] = '{3,  1,  10,   5,    0,   0, 0};
        vecs[2] = '{0,  0,  -1,   -1,   0,   0, 0};
        vecs[3] = '{5,  0,  7,    -1,   1,   0, 0};
        vecs[4] = '{3,  3,  3,    -1,   0,   1, 0};
        vecs[5] = '{6,  9,  4,    12,   1,   0, 0};
        vecs[6] = '{1,  2,  0,    0,    1,   0, 0};
        for (int k = 0; k < NV; k++) run_frame(vecs[k]);

        abort_test();
        run_frame('{2, 3, 1, 2, 0, 0, 0});
        reset_test();
        run_frame('{3, 2, 2, 2, 1, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
